// File: rtl/o232c_fifo.sv
`default_nettype none
// ============================================================================
// Module   : o232c_fifo
// Purpose  : Buffered RS-232C transmitter. Bytes written into a FIFO are sent
//            LSB-first as 8N1 frames (8E1 when O232C_PARITY_EN is defined).
// Revision : 1.0  initial release
// ============================================================================
module o232c_fifo #(
    parameter logic [15:0] wtime     = 16'h1B16,
    parameter int          LOG_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 XRST,
    input  logic [7:0]           data,
    input  logic                 wr,
    output logic                 full,
    output logic                 busy,
    output logic                 overflow,
    output logic [LOG_DEPTH:0]   count,
    output logic                 tx
);

    localparam int                 c_DEPTH_N = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] c_DEPTH   = {1'b1, {LOG_DEPTH{1'b0}}};
    localparam logic [15:0]        c_RELOAD  = wtime - 16'd1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef O232C_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [15:0]            r_timer;
    logic [15:0]            w_timer_nx;
    logic [2:0]             r_bit_idx;
    logic [2:0]             w_idx_nx;
    logic [7:0]             r_shift;
    logic [7:0]             w_shift_nx;
    logic                   r_tx;
    logic                   w_tx_nx;
`ifdef O232C_PARITY_EN
    logic                   r_parity;
`endif

    logic [7:0]             r_mem [c_DEPTH_N];
    logic [LOG_DEPTH-1:0]   r_wr_ptr;
    logic [LOG_DEPTH-1:0]   r_rd_ptr;
    logic [LOG_DEPTH:0]     r_count;
    logic [LOG_DEPTH:0]     w_count_nx;
    logic                   r_full;
    logic                   r_overflow;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_have_data;
    logic                   w_bit_end;
    logic [7:0]             w_head;

    assign w_push      = wr & ~r_full;
    assign w_have_data = (r_count != '0);
    assign w_bit_end   = (r_timer == 16'd0);
    assign w_head      = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        w_count_nx = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nx = r_count + (LOG_DEPTH+1)'(1);
            2'b01:   w_count_nx = r_count - (LOG_DEPTH+1)'(1);
            default: w_count_nx = r_count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + LOG_DEPTH'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + LOG_DEPTH'(1);
            r_count <= w_count_nx;
            r_full  <= (w_count_nx == c_DEPTH);
            // A pop on the same edge never rescues a write issued while full.
            if (wr && r_full) r_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_idx_nx   = r_bit_idx;
        w_shift_nx = r_shift;
        w_tx_nx    = r_tx;
        w_pop      = 1'b0;

        if (r_state != S_IDLE) begin
            w_timer_nx = w_bit_end ? c_RELOAD : (r_timer - 16'd1);
        end

        case (r_state)
            S_IDLE: begin
                w_tx_nx = 1'b1;
                if (w_have_data) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_head;
                    w_tx_nx    = 1'b0;
                    w_timer_nx = c_RELOAD;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_tx_nx    = r_shift[0];
                    w_idx_nx   = 3'd0;
                    w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef O232C_PARITY_EN
                        w_tx_nx    = r_parity;
                        w_state_nx = S_PARITY;
`else
                        w_tx_nx    = 1'b1;
                        w_state_nx = S_STOP;
`endif
                    end else begin
                        w_shift_nx = {1'b0, r_shift[7:1]};
                        w_tx_nx    = r_shift[1];
                        w_idx_nx   = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef O232C_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_tx_nx    = 1'b1;
                    w_state_nx = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (w_bit_end) begin
                    if (w_have_data) begin
                        w_pop      = 1'b1;
                        w_shift_nx = w_head;
                        w_tx_nx    = 1'b0;
                        w_state_nx = S_START;
                    end else begin
                        w_tx_nx    = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                w_tx_nx    = 1'b1;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            r_state   <= S_IDLE;
            r_timer   <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_timer   <= w_timer_nx;
            r_bit_idx <= w_idx_nx;
            r_shift   <= w_shift_nx;
            r_tx      <= w_tx_nx;
        end
    end

`ifdef O232C_PARITY_EN
    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_head;
        end
    end
`endif

    assign tx       = r_tx;
    assign full     = r_full;
    assign overflow = r_overflow;
    assign count    = r_count;
    assign busy     = (r_state != S_IDLE) || w_have_data;

endmodule
`default_nettype wire

// File: tb/tb_o232c_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_o232c_fifo
// Purpose  : Directed self-checking bench for o232c_fifo (wtime=6, depth 16).
// Revision : 1.0  initial release
// ============================================================================
module tb_o232c_fifo;

    localparam int c_WTI = 6;
`ifdef O232C_PARITY_EN
    localparam int c_NBITS = 11;
`else
    localparam int c_NBITS = 10;
`endif
    localparam int c_FRAME = c_NBITS * c_WTI;

    logic       CLK  = 1'b0;
    logic       XRST = 1'b0;
    logic [7:0] data = 8'h00;
    logic       wr   = 1'b0;
    wire        full;
    wire        busy;
    wire        overflow;
    wire  [4:0] count;
    wire        tx;

    int n_pass   = 0;
    int n_checks = 0;

    o232c_fifo #(
        .wtime     (16'd6),
        .LOG_DEPTH (4)
    ) u_dut (
        .CLK      (CLK),
        .XRST     (XRST),
        .data     (data),
        .wr       (wr),
        .full     (full),
        .busy     (busy),
        .overflow (overflow),
        .count    (count),
        .tx       (tx)
    );

    initial forever #7 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Samples tx once per cycle from frame cycle first_c (current negedge)
    // up to the last stop-bit cycle; every bit must be flat for wtime cycles.
    task automatic capture_frame(input int first_c, output logic [7:0] b,
                                 output logic p, output bit ok);
        logic val [c_NBITS];
        ok = 1'b1;
        for (int i = 0; i < c_NBITS; i++) val[i] = 1'b0;
        for (int c = first_c; c < c_FRAME; c++) begin
            if (c != first_c) @(negedge CLK);
            if ((c % c_WTI) == 0) val[c / c_WTI] = tx;
            else if (tx !== val[c / c_WTI]) ok = 1'b0;
        end
        if (val[0] !== 1'b0 || val[c_NBITS-1] !== 1'b1) ok = 1'b0;
        for (int i = 0; i < 8; i++) b[i] = val[i+1];
        p = val[9];
    endtask

    initial begin
        logic [7:0] b;
        logic       p;
        bit         ok;
        bit         idle_ok;

        // Reset and idle
        repeat (3) @(negedge CLK);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        XRST = 1'b1;
        idle_ok = 1'b1;
        repeat (200) begin
            @(negedge CLK);
            if (tx !== 1'b1 || busy !== 1'b0 || count !== 5'd0 || full !== 1'b0) idle_ok = 1'b0;
        end
        check("idle_200", idle_ok, 1);

        // Single byte 0x31
        data = 8'h31; wr = 1'b1;
        @(negedge CLK); wr = 1'b0;
        check("lat_tx_hi", tx, 1);
        check("lat_count", count, 1);
        check("lat_busy", busy, 1);
        @(negedge CLK);
        check("lat_tx_lo", tx, 0);
        check("lat_count0", count, 0);
        capture_frame(0, b, p, ok);
        check("b31_data", b, 8'h31);
        check("b31_shape", ok, 1);
`ifdef O232C_PARITY_EN
        check("b31_parity", p, 1);
`endif
        check("b31_busy_last", busy, 1);
        @(negedge CLK);
        check("b31_busy_end", busy, 0);
        check("b31_tx_idle", tx, 1);

        // Back-to-back bytes 1..4
        data = 8'd1; wr = 1'b1;
        @(negedge CLK); data = 8'd2;
        @(negedge CLK); data = 8'd3;
        check("b2b_tx_start", tx, 0);
        @(negedge CLK); data = 8'd4;
        @(negedge CLK); wr = 1'b0;
        check("b2b_count3", count, 3);
        capture_frame(2, b, p, ok);
        check("b2b_data1", b, 1);
        check("b2b_shape1", ok, 1);
        for (int i = 2; i <= 4; i++) begin
            @(negedge CLK);
            check("b2b_gap", tx, 0);
            capture_frame(0, b, p, ok);
            check("b2b_data", b, i);
            check("b2b_shape", ok, 1);
        end
        @(negedge CLK);
        check("b2b_busy_end", busy, 0);

        // Fill to full while an 0xFF frame is in flight
        data = 8'hFF; wr = 1'b1;
        @(negedge CLK); wr = 1'b0;
        @(negedge CLK);
        check("fill_tx_start", tx, 0);
        for (int d = 0; d < 17; d++) begin
            data = d[7:0]; wr = 1'b1;
            if (d == 15) check("fill_notfull15", full, 0);
            if (d == 16) begin
                check("fill_count16", count, 16);
                check("fill_full", full, 1);
                check("fill_ovf_pre", overflow, 0);
            end
            @(negedge CLK);
        end
        wr = 1'b0;
        check("fill_ovf", overflow, 1);
        check("fill_count_hold", count, 16);
        check("fill_full_hold", full, 1);
        repeat (c_FRAME - 17) @(negedge CLK);
        check("fill_next_start", tx, 0);
        check("fill_count15", count, 15);
        check("fill_full_clr", full, 0);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge CLK);
            capture_frame(0, b, p, ok);
            check("fill_order", b, i);
            check("fill_shape", ok, 1);
        end
        @(negedge CLK);
        check("fill_busy_end", busy, 0);
        check("fill_ovf_sticky", overflow, 1);

        // Push and pop on the same STOP-boundary edge
        data = 8'h5A; wr = 1'b1;
        @(negedge CLK); data = 8'hC3;
        @(negedge CLK); wr = 1'b0;
        check("pp_count1", count, 1);
        capture_frame(0, b, p, ok);
        check("pp_data_5a", b, 8'h5A);
        data = 8'h96; wr = 1'b1;
        @(negedge CLK); wr = 1'b0;
        check("pp_count_same", count, 1);
        check("pp_no_gap", tx, 0);
        capture_frame(0, b, p, ok);
        check("pp_data_c3", b, 8'hC3);
        check("pp_shape", ok, 1);
        @(negedge CLK);
        check("pp_no_gap2", tx, 0);
        capture_frame(0, b, p, ok);
        check("pp_data_96", b, 8'h96);
        @(negedge CLK);
        check("pp_busy_end", busy, 0);

        // Asynchronous reset in the middle of the data bits
        data = 8'h00; wr = 1'b1;
        @(negedge CLK); data = 8'h77;
        @(negedge CLK); wr = 1'b0;
        repeat (20) @(negedge CLK);
        check("mid_tx_low", tx, 0);
        check("mid_count", count, 1);
        #3 XRST = 1'b0;
        #1;
        check("arst_tx", tx, 1);
        check("arst_count", count, 0);
        check("arst_ovf", overflow, 0);
        check("arst_busy", busy, 0);
        @(negedge CLK); XRST = 1'b1;
        repeat (3) @(negedge CLK);
        check("post_rst_idle", busy, 0);
        data = 8'hA5; wr = 1'b1;
        @(negedge CLK); wr = 1'b0;
        @(negedge CLK);
        check("a5_start", tx, 0);
        capture_frame(0, b, p, ok);
        check("a5_data", b, 8'hA5);
        check("a5_shape", ok, 1);
`ifdef O232C_PARITY_EN
        check("a5_parity", p, 0);
`endif
        @(negedge CLK);
        check("a5_busy_end", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/o232c_fifo.md
Name: o232c_fifo

Overview:
- Buffered RS-232C transmitter. It accepts bytes from the core over a write strobe, queues them in an internal FIFO, and serialises them LSB-first as 8N1 frames on the board's RS_TX pin.
- It is the sending counterpart to the i232c receiver, and uses the same wtime bit-period convention so the two interoperate at identical settings.
- In top, it sits between the output-port logic and RS_TX.

Parameters:
- wtime, 16'h1B16: bit period in CLK cycles. Each serial bit is held for exactly wtime cycles. Legal range is 2 or more.
- LOG_DEPTH, 4: log2 of FIFO depth, so the default depth is 16 entries.

Ports:
- CLK  input  1  system clock.
- XRST  input  1  asynchronous active-low reset.
- data  input  8  byte to enqueue.
- wr  input  1  write strobe. Enqueues data on any CLK edge where wr=1 and full=0.
- full  output  1  FIFO holds 2^LOG_DEPTH entries.
- busy  output  1  frame in progress or FIFO non-empty.
- overflow  output  1  sticky. Set when wr=1 while full=1.
- count  output  LOG_DEPTH+1  current FIFO occupancy.
- tx  output  1  serial line. Idles high.

Behaviour:
- Reset (XRST=0, asynchronous): tx=1, full=0, busy=0, overflow=0, count=0. FIFO pointers cleared, FSM in IDLE, bit counter 0.
  - Reset mid-frame aborts the frame; tx returns high immediately.
- FIFO:
  - Circular buffer with LOG_DEPTH-bit read/write pointers that wrap naturally.
  - count and full are registered and update on the same edge as the push or pop.
  - Write while full: data is dropped, pointers are unchanged, overflow is set to 1 and stays set until reset.
  - Push and pop on the same edge: both take effect and count is unchanged. With full=1, a simultaneous pop does not make the write legal; the write is dropped and flagged.
- Bit timer:
  - Down-counter loaded with wtime-1 at each bit start.
  - The bit ends when the counter reaches 0, so each bit lasts exactly wtime cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - tx=1.
    - If count>0: pop the head byte into an 8-bit shift register, drive tx=0, go to START.
  - START:
    - Hold tx=0 for wtime cycles.
    - Then drive shift[0] and go to DATA with bit index 0.
  - DATA:
    - Each bit lasts wtime cycles, then the register shifts right and the index increments.
    - After bit 7, drive tx=1 and go to STOP.
  - STOP:
    - Hold tx=1 for wtime cycles.
    - At the end of the stop bit, if count>0, pop and enter START directly with no idle gap. Otherwise go to IDLE.
- Latency: a byte written at edge k into an empty, idle block drives tx low after edge k+1.
- Frame length: 10*wtime cycles.
- tx is driven directly from a flop and is glitch-free.
- busy = (state != IDLE) or (count != 0).

Optional Feature:
- Macro: O232C_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits even parity (XOR of the 8 data bits) for wtime cycles.
  - Frame becomes 8E1, 11*wtime cycles.
- Undefined: no parity state; 8N1 frame of 10*wtime cycles.

Test Plan:
- Reset then idle, wtime=6, clock period 14 ns: tx=1, busy=0, count=0, full=0 for 200 cycles.
- Single byte 8'h31, wtime=6:
  - tx falls at edge k+1, then each bit holds for 6 cycles (84 ns).
  - Expected sequence: 0, 1,0,0,0,1,1,0,0, 1.
  - An i232c instance with wtime=6 reports data=8'h31 with changed pulsed once.
  - busy drops after 60 cycles.
- Back-to-back bytes 1,2,3,4 written on consecutive cycles:
  - count reaches 3 after the first pop.
  - Frames are contiguous: each stop bit is followed immediately by a start bit.
  - The receiver sees 1,2,3,4 in order.
- Fill to full (LOG_DEPTH=4):
  - Write 17 bytes 8'h00..8'h10 while the first frame is in flight.
  - full=1 after the 16th FIFO entry; byte 8'h10 is dropped and overflow=1.
  - Transmitted order is 00..0F.
- Simultaneous push and pop at a STOP boundary with count=1: count stays 1 and the next frame starts without a gap.
- XRST pulled low mid-DATA:
  - tx=1 within the same cycle, with no flop delay.
  - count=0, overflow=0.
  - After release, new byte 8'hA5 is transmitted correctly.
  - With O232C_PARITY_EN defined, the parity bit for 8'hA5 is 0.
